iir_result_writer: RTL

//  Downstream stage of the IIR filter core. Captures each filtered sample (data, WAddr) on the cycle the core raises WEN.

---
 rtl/iir_result_writer_if.sv | 46 ++++
 rtl/iir_result_writer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/iir_result_writer_if.sv
// ---------------------------------------------------------------------------------------------
// iir_result_writer_if
//   Bundles the two handshake sides of the IIR result writer.
//   Sample side : in_wen, in_data, in_addr, in_finish   (filter core -> writer)
//   Memory side : mem_wr_req, mem_wr_addr, mem_wr_data  (writer -> result memory)
//                 mem_wr_ack                            (result memory -> writer)
//   Modports:
//     slave  - the writer itself
//     master - the environment driving samples and answering memory writes
// ---------------------------------------------------------------------------------------------
interface iir_result_writer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 20
);
    logic              in_wen;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_addr;
    logic              in_finish;

    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ack;

    modport slave (
        input  in_wen,
        input  in_data,
        input  in_addr,
        input  in_finish,
        input  mem_wr_ack,
        output mem_wr_req,
        output mem_wr_addr,
        output mem_wr_data
    );

    modport master (
        output in_wen,
        output in_data,
        output in_addr,
        output in_finish,
        output mem_wr_ack,
        input  mem_wr_req,
        input  mem_wr_addr,
        input  mem_wr_data
    );
endinterface

// File: rtl/iir_result_writer.sv
// ---------------------------------------------------------------------------------------------
// iir_result_writer
//   Downstream stage of the IIR filter core. Each sample the core flags with in_wen is queued
//   in a small FIFO and then written to the result memory over a req/ack handshake, strictly in
//   arrival order. Once the core signals finish and the FIFO has drained, done is raised and
//   stays up until reset.
//
//   Ports:
//     clk        - rising-edge clock
//     rst        - asynchronous active-low reset
//     bus        - iir_result_writer_if.slave (sample input and memory write handshake)
//     fifo_level - number of samples currently buffered (0..DEPTH)
//     overflow   - sticky, a sample was dropped on a full FIFO
//     wr_count   - acknowledged writes, wraps modulo 2^ADDR_W
//     done       - sticky, finish seen and all buffered samples written
// ---------------------------------------------------------------------------------------------
module iir_result_writer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    iir_result_writer_if.slave   bus,
    output logic [LVL_W-1:0]     fifo_level,
    output logic                 overflow,
    output logic [ADDR_W-1:0]    wr_count,
    output logic                 done
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    state_e state_q, state_d;

    // FIFO storage; contents need no reset since the pointers define validity.
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    // One extra pointer bit separates full from empty.
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0] rd_ptr_next;

    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_count_q;
    logic              overflow_q;
    logic              finish_q;

    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic              more_stored;

    assign fifo_level  = wr_ptr_q - rd_ptr_q;
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rd_ptr_next = rd_ptr_q + 1'b1;

    // The head is retired only while a request is actually on the bus.
    assign pop  = (state_q == StReq) && bus.mem_wr_ack;

    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push = bus.in_wen && (state_q != StDone) && (!full || pop);
    assign drop = bus.in_wen && (state_q != StDone) && full && !pop;

    // Entries other than the one being popped already sit in storage.
    assign more_stored = (fifo_level > LVL_W'(1));

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q[PTR_W-1:0]] <= bus.in_data;
            addr_mem[wr_ptr_q[PTR_W-1:0]] <= bus.in_addr;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d   = StReq;
                    wr_addr_d = addr_mem[rd_ptr_q[PTR_W-1:0]];
                    wr_data_d = data_mem[rd_ptr_q[PTR_W-1:0]];
                end else if (finish_q && !bus.in_wen) begin
                    // A sample arriving now must still be written before done.
                    state_d = StDone;
                end
            end
            StReq: begin
                if (pop) begin
                    if (more_stored) begin
                        wr_addr_d = addr_mem[rd_ptr_next[PTR_W-1:0]];
                        wr_data_d = data_mem[rd_ptr_next[PTR_W-1:0]];
                    end else if (push) begin
                        // The sample landing this edge becomes the new head; forward it.
                        wr_addr_d = bus.in_addr;
                        wr_data_d = bus.in_data;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_count_q <= '0;
            overflow_q <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_next;
                wr_count_q <= wr_count_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (bus.in_finish) begin
                finish_q <= 1'b1;
            end
        end
    end

    assign bus.mem_wr_req  = (state_q == StReq);
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign overflow        = overflow_q;
    assign wr_count        = wr_count_q;
    assign done            = (state_q == StDone);

endmodule
